// File: rtl/mul_share_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals around the shared multiplier arbiter.
// slave is the arbiter's view; master is the environment (requesters plus multiplier).
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rsp_data;
  logic                   busy;
  logic [IDX_W-1:0]       grant_id;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [WIDTH-1:0]       mul_result;
  logic                   mul_done;

  modport slave (
    input  req, a_in, b_in, mul_result, mul_done,
    output ack, rsp_data, busy, grant_id, mul_start, mul_a, mul_b
  );

  modport master (
    output req, a_in, b_in, mul_result, mul_done,
    input  ack, rsp_data, busy, grant_id, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one start/done multiplier among N_REQ requesters.
// Operands are captured at grant; the product returns with a one-hot, one-cycle ack.
module mul_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  mul_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]   rsp_q, rsp_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   last_q, last_d;

  // Round-robin pick: first set request strictly after the last served index.
  logic               found;
  logic [IDX_W-1:0]   pick;
  int                 idx;

  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    ack_d   = ack_q;
    rsp_d   = rsp_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    start_d = start_q;
    a_d     = a_q;
    b_d     = b_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          a_d     = bus.a_in[pick*WIDTH +: WIDTH];
          b_d     = bus.b_in[pick*WIDTH +: WIDTH];
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        // mul_done may still be high from the previous operation; ignore it here.
        start_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          rsp_d   = bus.mul_result;
          ack_d   = N_REQ'(1) << grant_q;
          last_d  = grant_q;
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      rsp_q   <= '0;
      busy_q  <= 1'b0;
      grant_q <= '0;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_data  = rsp_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
  assign bus.mul_start = start_q;
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a fixed-latency multiplier model (L cycles).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mul_share_arbiter;
  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int IDX_W = 2;
  localparam int L     = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  mul_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done rises L cycles after the start cycle; sticky mode holds it until the next start.
  bit               sticky = 1'b0;
  int               mcnt;
  logic             done_m;
  logic [WIDTH-1:0] res_m;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcnt   <= 0;
      done_m <= 1'b0;
      res_m  <= '0;
    end else if (bus.mul_start) begin
      mcnt   <= L - 1;
      done_m <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        done_m <= 1'b1;
        res_m  <= WIDTH'(bus.mul_a * bus.mul_b);
      end
    end else if (!sticky) begin
      done_m <= 1'b0;
    end
  end

  assign bus.mul_done   = done_m;
  assign bus.mul_result = res_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.a_in[i*WIDTH +: WIDTH] = a;
    bus.b_in[i*WIDTH +: WIDTH] = b;
  endtask

  // Advances falling edges until ack appears or the budget runs out; returns the ack cycle.
  task automatic wait_ack(input string tag, output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int at;
    int prev;

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack",       32'(bus.ack),       32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_grant",     32'(bus.grant_id),  32'd0);
    check("rst_start",     32'(bus.mul_start), 32'd0);
    check("rst_mul_a",     32'(bus.mul_a),     32'd0);
    check("rst_rsp",       32'(bus.rsp_data),  32'd0);
    reset = 1'b1;

    // Single request: 3*5, ack 12 cycles after the request cycle
    @(negedge clk);
    set_op(0, 16'd3, 16'd5);
    bus.req = 4'b0001;
    t = cyc;
    @(negedge clk);
    check("t1_start",      32'(bus.mul_start), 32'd1);
    check("t1_mul_a",      32'(bus.mul_a),     32'd3);
    check("t1_mul_b",      32'(bus.mul_b),     32'd5);
    check("t1_busy",       32'(bus.busy),      32'd1);
    check("t1_grant",      32'(bus.grant_id),  32'd0);
    @(negedge clk);
    check("t1_start_once", 32'(bus.mul_start), 32'd0);
    wait_ack("t1", at);
    check("t1_ack",        32'(bus.ack),       32'b0001);
    check("t1_rsp",        32'(bus.rsp_data),  32'd15);
    check("t1_latency",    32'(at - t),        32'd12);
    bus.req = '0;
    @(negedge clk);
    check("t1_ack_drop",   32'(bus.ack),       32'd0);
    check("t1_idle_busy",  32'(bus.busy),      32'd0);
    check("t1_rsp_hold",   32'(bus.rsp_data),  32'd15);

    // All four requesting from reset, operands (i+1, 2)
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_op(i, WIDTH'(i + 1), 16'd2);
    bus.req = 4'b1111;
    t    = cyc;
    prev = t;
    for (int k = 0; k < 5; k++) begin
      wait_ack($sformatf("rr%0d", k), at);
      check($sformatf("rr%0d_ack", k),  32'(bus.ack),      32'(1) << (k % N_REQ));
      check($sformatf("rr%0d_rsp", k),  32'(bus.rsp_data), 32'(2 * ((k % N_REQ) + 1)));
      check($sformatf("rr%0d_gap", k),  32'(at - prev),    (k == 0) ? 32'd12 : 32'd13);
      prev = at;
    end
    bus.req = '0;
    @(negedge clk);

    // Stale done: second operation must carry the new product at normal latency
    sticky = 1'b1;
    set_op(1, 16'd4, 16'd5);
    bus.req = 4'b0010;
    wait_ack("st_a", at);
    check("st_a_ack",      32'(bus.ack),       32'b0010);
    check("st_a_rsp",      32'(bus.rsp_data),  32'd20);
    bus.req = '0;
    @(negedge clk);
    set_op(2, 16'd6, 16'd7);
    bus.req = 4'b0100;
    t = cyc;
    @(negedge clk);
    check("st_done_stale", 32'(bus.mul_done),  32'd1);
    @(negedge clk);
    check("st_no_early",   32'(bus.ack),       32'd0);
    wait_ack("st_b", at);
    check("st_b_ack",      32'(bus.ack),       32'b0100);
    check("st_b_rsp",      32'(bus.rsp_data),  32'd42);
    check("st_b_latency",  32'(at - t),        32'd12);
    bus.req = '0;
    sticky  = 1'b0;
    @(negedge clk);

    // Operand change after grant must not reach the multiplier
    set_op(0, 16'd7, 16'd3);
    bus.req = 4'b0001;
    @(negedge clk);
    check("op_grant",      32'(bus.grant_id),  32'd0);
    @(negedge clk);
    set_op(0, 16'd9, 16'd3);
    @(negedge clk);
    check("op_mul_a_hold", 32'(bus.mul_a),     32'd7);
    wait_ack("op", at);
    check("op_ack",        32'(bus.ack),       32'b0001);
    check("op_rsp",        32'(bus.rsp_data),  32'd21);
    bus.req = '0;
    @(negedge clk);

    // Requests arriving while busy: 2 then 0 after serving 1
    set_op(1, 16'd5, 16'd5);
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    set_op(2, 16'd3, 16'd3);
    bus.req[2] = 1'b1;
    repeat (2) @(negedge clk);
    set_op(0, 16'd2, 16'd11);
    bus.req[0] = 1'b1;
    wait_ack("ord1", at);
    check("ord1_ack",      32'(bus.ack),       32'b0010);
    check("ord1_rsp",      32'(bus.rsp_data),  32'd25);
    bus.req[1] = 1'b0;
    wait_ack("ord2", at);
    check("ord2_ack",      32'(bus.ack),       32'b0100);
    check("ord2_rsp",      32'(bus.rsp_data),  32'd9);
    bus.req[2] = 1'b0;
    wait_ack("ord0", at);
    check("ord0_ack",      32'(bus.ack),       32'b0001);
    check("ord0_rsp",      32'(bus.rsp_data),  32'd22);
    bus.req[0] = 1'b0;
    @(negedge clk);

    // Reset during WAIT clears outputs at once; the held request is served after release
    set_op(2, 16'd8, 16'd8);
    bus.req = 4'b0100;
    repeat (3) @(negedge clk);
    check("mr_busy_pre",   32'(bus.busy),      32'd1);
    reset = 1'b0;
    #1;
    check("mr_busy",       32'(bus.busy),      32'd0);
    check("mr_start",      32'(bus.mul_start), 32'd0);
    check("mr_ack",        32'(bus.ack),       32'd0);
    check("mr_grant",      32'(bus.grant_id),  32'd0);
    check("mr_mul_a",      32'(bus.mul_a),     32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t = cyc;
    wait_ack("mr", at);
    check("mr_ack_after",  32'(bus.ack),       32'b0100);
    check("mr_rsp",        32'(bus.rsp_data),  32'd64);
    check("mr_latency",    32'(at - t),        32'd12);
    bus.req = '0;
    @(negedge clk);
    check("mr_idle_busy",  32'(bus.busy),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one start/done multiplier (the 16-bit Karatsuba unit) between N_REQ requesters, using round-robin arbitration.
- Latches the granted requester's operands and pulses the multiplier start for one cycle.
- Waits for done, then returns the product on a shared response bus with a one-hot, one-cycle ack.
- Sits between the CPU execute stage, address-generation logic and the single multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand and result width; values pass through uninterpreted, including sign.
- IDX_W, 2, grant index width; must satisfy 2**IDX_W >= N_REQ.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- req  in  N_REQ  per-requester request; held high with stable operands until that requester's ack.
- a_in  in  N_REQ*WIDTH  operand A; requester i drives a_in[i*WIDTH +: WIDTH].
- b_in  in  N_REQ*WIDTH  operand B, same packing as a_in.
- ack  out  N_REQ  one-hot, one-cycle completion strobe.
- rsp_data  out  WIDTH  product; valid only while ack != 0.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  IDX_W  index of the requester currently being served; holds the last value when idle.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  WIDTH  operand A to the multiplier; stable from START until the next grant.
- mul_b  out  WIDTH  operand B to the multiplier; same stability rule as mul_a.
- mul_result  in  WIDTH  multiplier product.
- mul_done  in  1  multiplier done; may remain high after completion until the next start.

Behaviour:
- All outputs are registered.
- Reset values:
  - state=IDLE, ack=0, rsp_data=0, busy=0, grant_id=0, mul_start=0, mul_a=0, mul_b=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- State machine (IDLE, START, WAIT, RESP):
  - IDLE:
    - If req != 0, pick the first set bit searching upward from (last+1) mod N_REQ.
    - Register grant_id, mul_a and mul_b from that requester's slice; set mul_start<=1 and go to START.
    - If req == 0, stay in IDLE.
  - START:
    - mul_start is high for this one cycle; set mul_start<=0 and go to WAIT.
    - mul_done is ignored in this cycle because it may be stale from the previous operation.
  - WAIT:
    - When mul_done==1: rsp_data<=mul_result, ack<=onehot(grant_id), last<=grant_id, go to RESP.
    - Otherwise stay in WAIT indefinitely; there is no timeout.
  - RESP:
    - ack and rsp_data are visible for exactly this cycle.
    - Set ack<=0 and go to IDLE; rsp_data holds its value.
- busy<=1 on leaving IDLE and busy<=0 on entering IDLE, so busy is high during START, WAIT and RESP.
- Latency:
  - req sampled in IDLE at cycle t gives mul_start high in cycle t+1.
  - If the multiplier raises done at cycle t+1+L, ack is high in cycle t+2+L.
  - IDLE is re-entered at t+3+L.
  - Minimum issue interval between grants is L+3 cycles.
- Handshake rules:
  - A requester drops req at the edge on which it samples ack. It is therefore low in the following IDLE cycle and is never double-granted.
  - A requester that keeps req high after ack is treated as issuing a new request and enters arbitration normally.
- Arbitration:
  - Only IDLE arbitrates.
  - Requests arriving while busy wait.
  - With all requesters continuously requesting, the grant order is 0,1,2,...,N_REQ-1,0,...
- Operand capture: a_in and b_in are sampled only in IDLE at grant time. Later changes on the requester side do not affect mul_a or mul_b.
- Reset mid-operation: reset==0 in any state returns everything to the reset values above, including the pointer.
  - The multiplier is reset by the same reset net.
  - No ack is issued for the aborted operation.
- No arithmetic is performed; widths pass straight through.

Test Plan:
- Single request: req=0001, a=3, b=5, multiplier model with L=10 → mul_start pulses one cycle with mul_a=3, mul_b=5; ack=0001 and rsp_data=15 exactly 12 cycles after the req cycle; busy is low afterwards.
- All four requesting from reset, operands (i+1, 2) → acks in order 0001, 0010, 0100, 1000, 0001 with rsp_data 2, 4, 6, 8, 2; each grant is L+3 cycles apart.
- Stale done: model keeps mul_done=1 until the next start → second operation is not acked in START; its ack carries the new product, not the old one.
- Operands changed during WAIT (a_in[0] goes 7→9 after grant) → mul_a stays 7; rsp_data = 7*b.
- Requester 2 requests while requester 1 is in WAIT, and requester 0 requests after → order is 2 then 0, following the round-robin pointer after 1.
- reset=0 asserted during WAIT → ack, busy and mul_start go to 0 immediately; with req=0100 held, the next grant after release is requester 2 and ack arrives normally.
